vco_adc_sample_fifo: RTL and testbench

VCO_ADC_SAMPLE_FIFO -- requirements
Module: vco_adc_sample_fifo

---
 rtl/vco_adc_sample_fifo.sv | 131 +++++++++++++
 tb/tb_vco_adc_sample_fifo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vco_adc_sample_fifo.sv
// Sample FIFO between the VCO ADC and a bus reader.
// Keeps sticky overflow/underflow flags and a registered fill-level interrupt.
module vco_adc_sample_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int THRESHOLD = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable_in,
    input  logic                       clear_in,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       data_valid_in,
    input  logic                       rd_in,
    output logic [WIDTH-1:0]           rd_data_out,
    output logic                       rd_valid_out,
    output logic [$clog2(DEPTH):0]     level_out,
    output logic                       empty_out,
    output logic                       full_out,
    output logic                       overflow_out,
    output logic                       underflow_out,
    output logic                       irq_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] THR_LVL  = LW'(THRESHOLD);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             irq_q, irq_d;

    logic empty;
    logic full;
    logic sample_in;
    logic rd_acc;
    logic wr_acc;

    assign empty     = (level_q == '0);
    assign full      = (level_q == FULL_LVL);
    assign sample_in = data_valid_in && enable_in && !clear_in;
    assign rd_acc    = rd_in && !empty && !clear_in;
    // A read in the same cycle frees the slot, so a full FIFO still takes the write.
    assign wr_acc    = sample_in && (!full || rd_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        irq_d       = (level_q >= THR_LVL);

        if (clear_in) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr_d   = rd_ptr_q + AW'(1);
                rd_data_d  = mem[rd_ptr_q];
                rd_valid_d = 1'b1;
            end
            if (rd_in && empty) begin
                underflow_d = 1'b1;
            end
            if (sample_in && full && !rd_acc) begin
                overflow_d = 1'b1;
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            irq_q       <= irq_d;
        end
    end

    // Storage is never reset; the level counter guards against stale reads.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    assign rd_data_out   = rd_data_q;
    assign rd_valid_out  = rd_valid_q;
    assign level_out     = level_q;
    assign empty_out     = empty;
    assign full_out      = full;
    assign overflow_out  = overflow_q;
    assign underflow_out = underflow_q;
    assign irq_out       = irq_q;

endmodule

// File: tb/tb_vco_adc_sample_fifo.sv
// Bench for vco_adc_sample_fifo: directed scenarios, random traffic and a
// long streaming run, all compared against a queue-based reference model.
module tb_vco_adc_sample_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int THR   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable_in;
    logic             clear_in;
    logic [WIDTH-1:0] data_in;
    logic             data_valid_in;
    logic             rd_in;
    logic [WIDTH-1:0] rd_data_out;
    logic             rd_valid_out;
    logic [4:0]       level_out;
    logic             empty_out;
    logic             full_out;
    logic             overflow_out;
    logic             underflow_out;
    logic             irq_out;

    int vectors = 0;
    int errors  = 0;

    logic [WIDTH-1:0] mq [$];
    logic [WIDTH-1:0] m_rd;
    logic             m_rv, m_ovf, m_udf, m_irq;
    int               pops;

    vco_adc_sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .THRESHOLD(THR)) dut (
        .clk(clk), .rst(rst), .enable_in(enable_in), .clear_in(clear_in),
        .data_in(data_in), .data_valid_in(data_valid_in), .rd_in(rd_in),
        .rd_data_out(rd_data_out), .rd_valid_out(rd_valid_out),
        .level_out(level_out), .empty_out(empty_out), .full_out(full_out),
        .overflow_out(overflow_out), .underflow_out(underflow_out),
        .irq_out(irq_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = mq.size();
        chk({tag, ".rd_valid"},  64'(rd_valid_out),  64'(m_rv));
        chk({tag, ".rd_data"},   64'(rd_data_out),   64'(m_rd));
        chk({tag, ".level"},     64'(level_out),     64'(sz));
        chk({tag, ".empty"},     64'(empty_out),     64'(sz == 0));
        chk({tag, ".full"},      64'(full_out),      64'(sz == DEPTH));
        chk({tag, ".overflow"},  64'(overflow_out),  64'(m_ovf));
        chk({tag, ".underflow"}, 64'(underflow_out), 64'(m_udf));
        chk({tag, ".irq"},       64'(irq_out),       64'(m_irq));
    endtask

    task automatic model_reset();
        mq.delete();
        m_rd  = '0;
        m_rv  = 1'b0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_irq = 1'b0;
    endtask

    // One clock cycle: apply inputs, let the edge happen, update model, compare.
    task automatic step(input string tag, input logic dv, input logic en,
                        input logic clr, input logic rd,
                        input logic [WIDTH-1:0] d);
        int  lvl;
        logic racc, wacc;
        data_valid_in = dv;
        enable_in     = en;
        clear_in      = clr;
        rd_in         = rd;
        data_in       = d;
        @(posedge clk);
        lvl   = mq.size();
        m_irq = (lvl >= THR);
        m_rv  = 1'b0;
        if (clr) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            racc = rd && (lvl > 0);
            wacc = dv && en && ((lvl < DEPTH) || racc);
            if (rd && lvl == 0) m_udf = 1'b1;
            if (dv && en && lvl == DEPTH && !racc) m_ovf = 1'b1;
            if (racc) begin
                m_rd = mq.pop_front();
                m_rv = 1'b1;
                pops++;
            end
            if (wacc) mq.push_back(d);
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [WIDTH-1:0] stream [2048];
        int k;
        rst = 1'b1;
        enable_in = 1'b0;
        clear_in = 1'b0;
        data_in = '0;
        data_valid_in = 1'b0;
        rd_in = 1'b0;
        pops = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Three samples then three reads
        step("w11", 1, 1, 0, 0, 32'h11);
        step("w22", 1, 1, 0, 0, 32'h22);
        step("w33", 1, 1, 0, 0, 32'h33);
        for (int i = 0; i < 3; i++) step("r3", 0, 1, 0, 1, '0);
        step("idle", 0, 1, 0, 0, '0);

        // Overfill: 17 writes, 16 reads
        for (int i = 0; i <= 16; i++) step("fill17", 1, 1, 0, 0, 32'(i));
        for (int i = 0; i < 16; i++) step("drain16", 0, 1, 0, 1, '0);
        step("clr1", 0, 1, 1, 0, '0);

        // Full with simultaneous read and write
        for (int i = 0; i < 16; i++) step("fill16", 1, 1, 0, 0, 32'h100 + 32'(i));
        step("rw_full", 1, 1, 0, 1, 32'hAA);
        for (int i = 0; i < 16; i++) step("drain_aa", 0, 1, 0, 1, '0);

        // Empty with read and write together
        step("clr2", 0, 1, 1, 0, '0);
        step("rw_empty", 1, 1, 0, 1, 32'h55);
        step("rd_55", 0, 1, 0, 1, '0);

        // Threshold interrupt
        step("clr3", 0, 1, 1, 0, '0);
        for (int i = 0; i < 8; i++) step("irq_fill", 1, 1, 0, 0, 32'h200 + 32'(i));
        step("irq_rise", 0, 1, 0, 0, '0);
        step("irq_rd", 0, 1, 0, 1, '0);
        step("irq_fall", 0, 1, 0, 0, '0);
        step("irq_w", 1, 1, 0, 0, 32'h300);
        step("irq_clr", 0, 1, 1, 1, '0);
        step("post_clr", 0, 1, 0, 0, '0);

        // Disabled capture drops samples silently
        for (int i = 0; i < 20; i++) step("disabled", 1, 0, 0, 0, 32'h400 + 32'(i));

        // Random traffic
        for (int i = 0; i < 600; i++)
            step("rand", 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), $urandom);

        // Reset in the middle of operation
        for (int i = 0; i < 5; i++) step("pre_rst", 1, 1, 0, 0, $urandom);
        rst = 1'b1;
        #2;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
        step("rst_rd", 0, 1, 0, 1, '0);
        step("rst_w", 1, 1, 0, 0, 32'h77);
        step("rst_r", 0, 1, 0, 1, '0);

        // Continuous stream with concurrent drain
        step("clr4", 0, 1, 1, 0, '0);
        for (int i = 0; i < 2048; i++) stream[i] = $urandom;
        pops = 0;
        k = 0;
        while (k < 2048 || mq.size() > 0) begin
            if (k < 2048) begin
                step("stream", 1, 1, 0, (mq.size() > 0), stream[k]);
                k++;
            end else begin
                step("stream_drain", 0, 1, 0, 1, '0);
            end
        end
        chk("stream.pops", 64'(pops), 64'd2048);
        chk("stream.last", 64'(rd_data_out), 64'(stream[2047]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
